stim_lcg_sequencer: RTL

STIM_LCG_SEQUENCER -- requirements
Module: stim_lcg_sequencer

---
 rtl/stim_lcg_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/stim_lcg_sequencer.sv
// Stimulus sequencer: resets a DUT, then presents num_cycles+1 LCG-filled vectors
// over a valid/ready handshake, one 32-bit LCG word per clock while generating.
module stim_lcg_sequencer #(
    parameter int IN_W         = 261,
    parameter int RESET_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [31:0]     seed,
    input  logic [31:0]     num_cycles,
    input  logic            abort,
    input  logic            stim_ready,
    output logic            dut_rst_n,
    output logic [IN_W-1:0] in_flat,
    output logic            stim_valid,
    output logic [31:0]     vec_idx,
    output logic            busy,
    output logic            done
);

    localparam int WORDS    = (IN_W + 31) / 32;
    localparam int SHADOW_W = WORDS * 32;
    localparam int WCNT_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int RCNT_W   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(WORDS - 1);
    localparam logic [RCNT_W-1:0] LAST_RST  = RCNT_W'(RESET_CYCLES - 1);
    localparam logic [31:0]       LCG_MUL   = 32'h41C64E6D;
    localparam logic [31:0]       LCG_INC   = 32'h0000_3039;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        GEN,
        APPLY,
        DONE
    } state_e;

    state_e                state_q,      state_d;
    logic [31:0]           lcg_q,        lcg_d;
    logic [SHADOW_W-1:0]   shadow_q,     shadow_d;
    logic [IN_W-1:0]       in_flat_q,    in_flat_d;
    logic [31:0]           vec_idx_q,    vec_idx_d;
    logic [31:0]           num_cycles_q, num_cycles_d;
    logic [RCNT_W-1:0]     rst_cnt_q,    rst_cnt_d;
    logic [WCNT_W-1:0]     word_cnt_q,   word_cnt_d;

    logic [31:0]           lcg_next;

    assign lcg_next = lcg_q * LCG_MUL + LCG_INC;

    // NOTE: every target gets its hold value first, so no path through this
    // block can leave a variable unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        lcg_d        = lcg_q;
        shadow_d     = shadow_q;
        in_flat_d    = in_flat_q;
        vec_idx_d    = vec_idx_q;
        num_cycles_d = num_cycles_q;
        rst_cnt_d    = rst_cnt_q;
        word_cnt_d   = word_cnt_q;

        if (abort && (state_q != IDLE)) begin
            // Abort wins over start and stim_ready; in_flat and vec_idx keep their values.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        lcg_d        = seed;
                        num_cycles_d = num_cycles;
                        vec_idx_d    = '0;
                        rst_cnt_d    = '0;
                        state_d      = RST;
                    end
                end

                RST: begin
                    if (rst_cnt_q == LAST_RST) begin
                        word_cnt_d = '0;
                        state_d    = GEN;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RCNT_W'(1);
                    end
                end

                GEN: begin
                    lcg_d = lcg_next;
                    for (int w = 0; w < WORDS; w++) begin
                        if (word_cnt_q == WCNT_W'(w)) begin
                            shadow_d[w*32 +: 32] = lcg_next;
                        end
                    end
                    if (word_cnt_q == LAST_WORD) begin
                        // The last word lands this same edge, so publish from shadow_d.
                        in_flat_d = shadow_d[IN_W-1:0];
                        state_d   = APPLY;
                    end else begin
                        word_cnt_d = word_cnt_q + WCNT_W'(1);
                    end
                end

                APPLY: begin
                    if (stim_ready) begin
                        if (vec_idx_q == num_cycles_q) begin
                            state_d = DONE;
                        end else begin
                            vec_idx_d  = vec_idx_q + 32'd1;
                            word_cnt_d = '0;
                            state_d    = GEN;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            lcg_q        <= '0;
            // NOTE: the shadow register is reset as well so that the unused tail of
            // the last word and any early read of in_flat can never carry X.
            shadow_q     <= '0;
            in_flat_q    <= '0;
            vec_idx_q    <= '0;
            num_cycles_q <= '0;
            rst_cnt_q    <= '0;
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            lcg_q        <= lcg_d;
            shadow_q     <= shadow_d;
            in_flat_q    <= in_flat_d;
            vec_idx_q    <= vec_idx_d;
            num_cycles_q <= num_cycles_d;
            rst_cnt_q    <= rst_cnt_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    // Status outputs decode the state directly, so an async reset clears them at once.
    always_comb begin
        dut_rst_n  = 1'b0;
        stim_valid = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            RST: begin
                busy = 1'b1;
            end
            GEN: begin
                dut_rst_n = 1'b1;
                busy      = 1'b1;
            end
            APPLY: begin
                dut_rst_n  = 1'b1;
                stim_valid = 1'b1;
                busy       = 1'b1;
            end
            DONE: begin
                dut_rst_n = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_flat = in_flat_q;
    assign vec_idx = vec_idx_q;

endmodule
